// File: rtl/data_mem_responder_pkg.sv
// Shared types for the data-memory responder.
// Holds FSM states, the latched request bundle and address checks.
package mem_bus_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS,
    RESP
  } mem_state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

  // Misaligned or beyond the last word of the array.
  function automatic logic addr_bad(
    input logic [31:0] a,
    input int unsigned depth
  );
    logic [31:0] lim;
    lim = 32'(WORD_BYTES * depth);
    return (a[1:0] != 2'b00) || (a >= lim);
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response handshake bundle between
// a memory initiator (master) and the responder (slave).
interface data_mem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid,
    output req_we,
    output req_addr,
    output req_wdata,
    output req_be,
    output resp_ready,
    input  req_ready,
    input  resp_valid,
    input  resp_rdata,
    input  resp_err
  );

  modport slave (
    input  req_valid,
    input  req_we,
    input  req_addr,
    input  req_wdata,
    input  req_be,
    input  resp_ready,
    output req_ready,
    output resp_valid,
    output resp_rdata,
    output resp_err
  );

endinterface

// File: rtl/data_mem_responder_be_word_ram.sv
// Word array with byte-enable synchronous write
// and combinational read; contents survive reset.
module be_word_ram
  import mem_bus_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [3:0]               i_be,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic [31:0]              i_wdata,
  output logic [31:0]              o_rdata
);

  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (i_be[i]) begin
          r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
        end
      end
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding data-memory responder with
// programmable wait states ahead of the array access.
module data_mem_responder
  import mem_bus_pkg::*;
#(
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input logic                 clk,
  input logic                 reset,
  data_mem_responder_if.slave bus
);

  localparam int AW = $clog2(MEM_DEPTH);

  mem_state_t  r_state;
  mem_state_t  w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  req_t        r_req;
  req_t        w_req_nxt;
  logic [31:0] r_rdata;
  logic [31:0] w_rdata_nxt;
  logic        r_err;
  logic        w_err_nxt;

  logic        w_bad;
  logic        w_wr;
  logic [31:0] w_ram_rdata;

  assign w_bad = addr_bad(r_req.addr, MEM_DEPTH);
  assign w_wr  = (r_state == ACCESS) && r_req.we && !w_bad;

  be_word_ram #(
    .DEPTH (MEM_DEPTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr),
    .i_be    (r_req.be),
    .i_addr  (r_req.addr[AW+1:2]),
    .i_wdata (r_req.wdata),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_req   <= '0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_req   <= w_req_nxt;
      r_rdata <= w_rdata_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_req_nxt   = r_req;
    w_rdata_nxt = r_rdata;
    w_err_nxt   = r_err;
    unique case (r_state)
      IDLE: begin
        if (bus.req_valid) begin
          w_req_nxt = '{
            we:    bus.req_we,
            addr:  bus.req_addr,
            wdata: bus.req_wdata,
            be:    bus.req_be
          };
          if (WAIT_CYCLES == 0) begin
            w_state_nxt = ACCESS;
          end else begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = 4'(WAIT_CYCLES);
          end
        end
      end
      WAIT: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) begin
          w_state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        // Stores and faulting accesses both return zero data.
        w_err_nxt   = w_bad;
        w_rdata_nxt = (r_req.we || w_bad) ? 32'd0 : w_ram_rdata;
        w_state_nxt = RESP;
      end
      RESP: begin
        if (bus.resp_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign bus.req_ready  = (r_state == IDLE);
  assign bus.resp_valid = (r_state == RESP);
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_err   = r_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: a W=2 and a W=0 instance,
// directed stores/loads with hand-computed responses.
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t q[$];
  exp_t q0[$];
  exp_t e;
  exp_t e0;

  data_mem_responder_if bus ();
  data_mem_responder_if bus0 ();

  data_mem_responder #(
    .MEM_DEPTH   (1024),
    .WAIT_CYCLES (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  data_mem_responder #(
    .MEM_DEPTH   (1024),
    .WAIT_CYCLES (0)
  ) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  // Monitors: latency on rising resp_valid, data on handshake
  logic pv = 1'b0;
  logic pv0 = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.resp_valid && !pv) begin
        if (q.size() == 0) flag("unexpected_resp");
        else chk("latency", 32'(cyc - q[0].cyc), 32'd3);
      end
      if (bus.resp_valid && bus.resp_ready && q.size() > 0) begin
        e = q.pop_front();
        chk("rdata", bus.resp_rdata, e.rdata);
        chk("err", {31'd0, bus.resp_err}, {31'd0, e.err});
      end
    end
    pv = bus.resp_valid;
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (bus0.resp_valid && !pv0) begin
        if (q0.size() == 0) flag("unexpected_resp0");
        else chk("latency0", 32'(cyc - q0[0].cyc), 32'd1);
      end
      if (bus0.resp_valid && bus0.resp_ready && q0.size() > 0) begin
        e0 = q0.pop_front();
        chk("rdata0", bus0.resp_rdata, e0.rdata);
        chk("err0", {31'd0, bus0.resp_err}, {31'd0, e0.err});
      end
    end
    pv0 = bus0.resp_valid;
  end

  task automatic send(input logic we, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] be,
                      input logic [31:0] er, input logic ee);
    int n;
    n = 0;
    @(negedge clk);
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    bus.req_be    = be;
    bus.req_valid = 1'b1;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      flag("accept_timeout");
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    q.push_back('{er, ee, cyc});
    // Scramble fields after accept; only the latched copy may be used.
    bus.req_valid = 1'b0;
    bus.req_we    = ~we;
    bus.req_addr  = 32'hFFFF_FFF0;
    bus.req_wdata = ~wd;
    bus.req_be    = 4'hF;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      flag("resp_timeout");
      q.delete();
    end
  endtask

  task automatic txn(input logic we, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] be,
                     input logic [31:0] er, input logic ee);
    send(we, a, wd, be, er, ee);
    wait_done();
  endtask

  logic        v_we [6];
  logic [31:0] v_a  [6];
  logic [31:0] v_wd [6];
  logic [31:0] v_er [6];

  initial begin
    int n;
    int last;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    bus.req_be     = 4'd0;
    bus.resp_ready = 1'b1;
    bus0.req_valid  = 1'b0;
    bus0.req_we     = 1'b0;
    bus0.req_addr   = 32'd0;
    bus0.req_wdata  = 32'd0;
    bus0.req_be     = 4'd0;
    bus0.resp_ready = 1'b1;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_rdata", bus.resp_rdata, 32'd0);
    chk("rst_err", {31'd0, bus.resp_err}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);

    // Basic store then load
    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'd0, 1'b0);
    txn(1'b0, 32'h10, 32'd0, 4'hF, 32'hDEADBEEF, 1'b0);

    // Byte-enable merge and be=0 no-op store
    txn(1'b1, 32'h20, 32'h11223344, 4'hF, 32'd0, 1'b0);
    txn(1'b1, 32'h20, 32'h0000AA00, 4'b0010, 32'd0, 1'b0);
    txn(1'b0, 32'h20, 32'd0, 4'd0, 32'h1122AA44, 1'b0);
    txn(1'b1, 32'h20, 32'hFFFFFFFF, 4'd0, 32'd0, 1'b0);
    txn(1'b0, 32'h20, 32'd0, 4'd0, 32'h1122AA44, 1'b0);

    // Errors: misaligned, out of range; aliased words untouched
    txn(1'b1, 32'h0, 32'hA5A5A5A5, 4'hF, 32'd0, 1'b0);
    txn(1'b1, 32'hFFC, 32'h12345678, 4'hF, 32'd0, 1'b0);
    txn(1'b0, 32'h6, 32'd0, 4'hF, 32'd0, 1'b1);
    txn(1'b1, 32'h1000, 32'hCAFEF00D, 4'hF, 32'd0, 1'b1);
    txn(1'b0, 32'h1000, 32'd0, 4'hF, 32'd0, 1'b1);
    txn(1'b1, 32'h12, 32'hFFFFFFFF, 4'hF, 32'd0, 1'b1);
    txn(1'b0, 32'hFFC, 32'd0, 4'hF, 32'h12345678, 1'b0);
    txn(1'b0, 32'h0, 32'd0, 4'hF, 32'hA5A5A5A5, 1'b0);
    txn(1'b0, 32'h10, 32'd0, 4'hF, 32'hDEADBEEF, 1'b0);

    // Back-pressure in RESP with request pulses that must be ignored
    bus.resp_ready = 1'b0;
    send(1'b0, 32'h10, 32'd0, 4'hF, 32'hDEADBEEF, 1'b0);
    n = 0;
    while (!bus.resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.resp_valid) flag("resp_valid_timeout");
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", {31'd0, bus.resp_valid}, 32'd1);
      chk("hold_rdata", bus.resp_rdata, 32'hDEADBEEF);
      chk("hold_req_ready", {31'd0, bus.req_ready}, 32'd0);
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_addr  = 32'h10;
      bus.req_wdata = 32'h0BAD0BAD;
      bus.req_be    = 4'hF;
      @(negedge clk);
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    wait_done();
    txn(1'b0, 32'h10, 32'd0, 4'hF, 32'hDEADBEEF, 1'b0);

    // Reset during WAIT of a store discards it
    txn(1'b1, 32'h8, 32'h77777777, 4'hF, 32'd0, 1'b0);
    txn(1'b0, 32'h8, 32'd0, 4'hF, 32'h77777777, 1'b0);
    send(1'b1, 32'h8, 32'h00000055, 4'hF, 32'd0, 1'b0);
    reset = 1'b1;
    #1;
    q.delete();
    chk("mid_rst_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("mid_rst_rdata", bus.resp_rdata, 32'd0);
    chk("mid_rst_err", {31'd0, bus.resp_err}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    txn(1'b0, 32'h8, 32'd0, 4'hF, 32'h77777777, 1'b0);

    // Zero-wait instance, request held valid continuously
    v_we = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    v_a  = '{32'h40, 32'h44, 32'h48, 32'h44, 32'h40, 32'h48};
    v_wd = '{32'h01010101, 32'h02020202, 32'h03030303,
             32'd0, 32'd0, 32'd0};
    v_er = '{32'd0, 32'd0, 32'd0,
             32'h02020202, 32'h01010101, 32'h03030303};
    last = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus0.req_we    = v_we[i];
      bus0.req_addr  = v_a[i];
      bus0.req_wdata = v_wd[i];
      bus0.req_be    = 4'hF;
      bus0.req_valid = 1'b1;
      n = 0;
      while (!bus0.req_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (!bus0.req_ready) begin
        flag("accept0_timeout");
        break;
      end
      @(posedge clk);
      #1;
      q0.push_back('{v_er[i], 1'b0, cyc});
      if (i > 0) chk("accept_gap", 32'(cyc - last), 32'd3);
      last = cyc;
    end
    bus0.req_valid = 1'b0;
    n = 0;
    while (q0.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (q0.size() != 0) flag("resp0_timeout");

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
